// File: rtl/packet_framer.sv
// packet_framer
//   Serialises 16-bit words into five-byte frames: SYNC, SEQ, DATA_HI,
//   DATA_LO, CSUM. The checksum covers SEQ, DATA_HI and DATA_LO only.
//   A one-word holding register lets the next frame start with no idle gap.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   data_in          16-bit word to transmit
//   data_valid       data_in is valid
//   data_ready       framer can take a word this cycle (= !hold_full)
//   packet_out       serialised byte (IDLE_BYTE when packet_out_valid=0)
//   packet_out_valid packet_out holds a frame byte
//   packet_out_ready downstream consumes packet_out this cycle
//   sof / eof        packet_out is the SYNC / CSUM byte
//   busy             frame in progress or holding register full
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. While valid=1 and ready=0 the presenting side holds its data
// (packet_out, sof, eof) stable.
module packet_framer #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] IDLE_BYTE = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic [7:0]  packet_out,
   output logic        packet_out_valid,
   input  logic        packet_out_ready,
   output logic        sof,
   output logic        eof,
   output logic        busy
);

   // The state names the byte currently presented on packet_out.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_SEQ  = 3'd2,
      ST_HI   = 3'd3,
      ST_LO   = 3'd4,
      ST_CSUM = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] frame_data, frame_data_nxt;
   logic [7:0]  frame_seq, frame_seq_nxt;
   logic [7:0]  seq_cnt, seq_cnt_nxt;
   logic [15:0] hold_data, hold_data_nxt;
   logic        hold_full, hold_full_nxt;
   logic [7:0]  byte_nxt;
   logic        accept;
   logic        consume;

   assign data_ready = !hold_full;
   assign accept     = data_valid && !hold_full;
   assign consume    = packet_out_valid && packet_out_ready;

   always_comb begin
      state_nxt      = state;
      frame_data_nxt = frame_data;
      frame_seq_nxt  = frame_seq;
      seq_cnt_nxt    = seq_cnt;
      hold_data_nxt  = hold_data;
      hold_full_nxt  = hold_full;
      case (state)
         ST_IDLE: begin
            // Holding register is always empty here, so the word goes
            // straight into the frame register.
            if (accept) begin
               frame_data_nxt = data_in;
               frame_seq_nxt  = seq_cnt;
               state_nxt      = ST_SYNC;
            end
         end
         ST_CSUM: begin
            if (consume) begin
               seq_cnt_nxt = seq_cnt + 8'd1;
               if (hold_full) begin
                  frame_data_nxt = hold_data;
                  frame_seq_nxt  = seq_cnt + 8'd1;
                  hold_full_nxt  = 1'b0;
                  state_nxt      = ST_SYNC;
               end else if (accept) begin
                  frame_data_nxt = data_in;
                  frame_seq_nxt  = seq_cnt + 8'd1;
                  state_nxt      = ST_SYNC;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (accept) begin
               hold_data_nxt = data_in;
               hold_full_nxt = 1'b1;
            end
         end
         default: begin
            if (consume) begin
               case (state)
                  ST_SYNC: state_nxt = ST_SEQ;
                  ST_SEQ:  state_nxt = ST_HI;
                  ST_HI:   state_nxt = ST_LO;
                  default: state_nxt = ST_CSUM;
               endcase
            end
            if (accept) begin
               hold_data_nxt = data_in;
               hold_full_nxt = 1'b1;
            end
         end
      endcase
   end

   // Byte for the next cycle, derived from the next-state frame contents so
   // the output registers line up with the state register.
   always_comb begin
      byte_nxt = IDLE_BYTE;
      case (state_nxt)
         ST_SYNC: byte_nxt = SYNC_BYTE;
         ST_SEQ:  byte_nxt = frame_seq_nxt;
         ST_HI:   byte_nxt = frame_data_nxt[15:8];
         ST_LO:   byte_nxt = frame_data_nxt[7:0];
         ST_CSUM: byte_nxt = frame_seq_nxt + frame_data_nxt[15:8] + frame_data_nxt[7:0];
         default: byte_nxt = IDLE_BYTE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         frame_data       <= 16'h0000;
         frame_seq        <= 8'h00;
         seq_cnt          <= 8'h00;
         hold_data        <= 16'h0000;
         hold_full        <= 1'b0;
         packet_out       <= IDLE_BYTE;
         packet_out_valid <= 1'b0;
         sof              <= 1'b0;
         eof              <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state            <= state_nxt;
         frame_data       <= frame_data_nxt;
         frame_seq        <= frame_seq_nxt;
         seq_cnt          <= seq_cnt_nxt;
         hold_data        <= hold_data_nxt;
         hold_full        <= hold_full_nxt;
         packet_out       <= byte_nxt;
         packet_out_valid <= (state_nxt != ST_IDLE);
         sof              <= (state_nxt == ST_SYNC);
         eof              <= (state_nxt == ST_CSUM);
         busy             <= (state_nxt != ST_IDLE) || hold_full_nxt;
      end
   end

endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer
//   Directed bench for packet_framer: single frame, back-to-back frames,
//   output backpressure, sequence wrap, mid-frame reset and idle link.
//   Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_packet_framer;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic        data_valid;
   logic        data_ready;
   logic [7:0]  packet_out;
   logic        packet_out_valid;
   logic        packet_out_ready;
   logic        sof;
   logic        eof;
   logic        busy;

   int test_cnt = 0;
   int fail_cnt = 0;

   packet_framer dut (
      .clk              (clk),
      .rst              (rst),
      .data_in          (data_in),
      .data_valid       (data_valid),
      .data_ready       (data_ready),
      .packet_out       (packet_out),
      .packet_out_valid (packet_out_valid),
      .packet_out_ready (packet_out_ready),
      .sof              (sof),
      .eof              (eof),
      .busy             (busy)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] make_frame(input logic [7:0] s, input logic [15:0] d);
      logic [7:0] cs;
      cs = s + d[15:8] + d[7:0];
      return {8'hA5, s, d[15:8], d[7:0], cs};
   endfunction

   task automatic chk_reset_values(input string name);
      chk({name, "_out"},   {24'h0, packet_out}, 32'h00);
      chk({name, "_valid"}, {31'h0, packet_out_valid}, 32'h0);
      chk({name, "_sof"},   {31'h0, sof}, 32'h0);
      chk({name, "_eof"},   {31'h0, eof}, 32'h0);
      chk({name, "_busy"},  {31'h0, busy}, 32'h0);
      chk({name, "_ready"}, {31'h0, data_ready}, 32'h1);
   endtask

   // Assert reset (asynchronous), check outputs before any clock edge,
   // then release 1 ns after a rising edge.
   task automatic do_reset(input string name);
      rst = 1'b1;
      #1;
      chk_reset_values(name);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // driver: present one word for one edge (framer must be ready)
   task automatic drive_word(input logic [15:0] d);
      data_in    = d;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   // Receive a frame from byte index 'start'. mode 0: ready always high;
   // mode 1: ready follows 1,0,0,1,0,0,... Every cycle checks the presented
   // byte, so a held byte that changes under ready=0 is caught.
   // A pending input word is withdrawn after it has been accepted.
   task automatic recv_frame(input string name, input logic [39:0] fr,
                             input int mode, input int start);
      int         idx;
      int         cyc;
      logic       rdy;
      logic       acc;
      logic [7:0] eb;
      idx = start;
      cyc = 0;
      while (idx < 5 && cyc < 60) begin
         rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
         packet_out_ready = rdy;
         eb = fr[(4 - idx) * 8 +: 8];
         chk({name, "_valid"}, {31'h0, packet_out_valid}, 32'h1);
         chk({name, "_byte"},  {24'h0, packet_out}, {24'h0, eb});
         chk({name, "_sof"},   {31'h0, sof}, {31'h0, (idx == 0)});
         chk({name, "_eof"},   {31'h0, eof}, {31'h0, (idx == 4)});
         acc = data_valid && data_ready;
         @(posedge clk);
         #1;
         if (acc) data_valid = 1'b0;
         if (rdy) idx++;
         cyc++;
      end
      chk({name, "_complete"}, idx, 5);
      packet_out_ready = 1'b1;
   endtask

   initial begin
      logic [15:0] d;
      rst              = 1'b0;
      data_in          = 16'h0000;
      data_valid       = 1'b0;
      packet_out_ready = 1'b1;
      #2;
      do_reset("reset");

      // single word
      drive_word(16'h1234);
      recv_frame("single", 40'hA5_00_12_34_46, 0, 0);
      chk("single_idle_valid", {31'h0, packet_out_valid}, 32'h0);
      chk("single_idle_out",   {24'h0, packet_out}, 32'h00);
      chk("single_idle_busy",  {31'h0, busy}, 32'h0);

      // back-to-back: second word lands in the holding register
      do_reset("reset_b2b");
      drive_word(16'h1234);
      data_in    = 16'hFFFF;
      data_valid = 1'b1;
      chk("b2b_ready_before", {31'h0, data_ready}, 32'h1);
      chk("b2b_sync", {24'h0, packet_out}, 32'hA5);
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      chk("b2b_ready_held", {31'h0, data_ready}, 32'h0);
      chk("b2b_busy_held",  {31'h0, busy}, 32'h1);
      recv_frame("b2b_f1", 40'hA5_00_12_34_46, 0, 1);
      chk("b2b_ready_drained", {31'h0, data_ready}, 32'h1);
      recv_frame("b2b_f2", 40'hA5_01_FF_FF_FF, 0, 0);
      chk("b2b_end_valid", {31'h0, packet_out_valid}, 32'h0);
      chk("b2b_end_busy",  {31'h0, busy}, 32'h0);

      // backpressure
      do_reset("reset_bp");
      drive_word(16'h00AB);
      recv_frame("bp", 40'hA5_00_00_AB_AB, 1, 0);
      chk("bp_end_valid", {31'h0, packet_out_valid}, 32'h0);

      // sequence wrap over 257 frames
      do_reset("reset_wrap");
      for (int i = 0; i < 257; i++) begin
         d = 16'($urandom_range(0, 65535));
         drive_word(d);
         recv_frame("wrap", make_frame(8'(i), d), 0, 0);
      end
      drive_word(16'h0000);
      recv_frame("wrap_257", 40'hA5_01_00_00_01, 0, 0);

      // reset while HI is presented with a word held
      do_reset("reset_mid");
      drive_word(16'h1111);
      data_in    = 16'h2222;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_hi_byte",   {24'h0, packet_out}, 32'h11);
      chk("mid_hold_full", {31'h0, data_ready}, 32'h0);
      do_reset("mid_abort");
      chk("mid_after_valid", {31'h0, packet_out_valid}, 32'h0);
      drive_word(16'h0102);
      recv_frame("after_reset", 40'hA5_00_01_02_03, 0, 0);

      // idle link
      data_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("idle_valid", {31'h0, packet_out_valid}, 32'h0);
         chk("idle_out",   {24'h0, packet_out}, 32'h00);
         chk("idle_busy",  {31'h0, busy}, 32'h0);
         chk("idle_ready", {31'h0, data_ready}, 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
